enigma_msg_feeder: RTL and testbench
====================================

ENIGMA_MSG_FEEDER -- requirements
Module: enigma_msg_feeder

Interface
REQ-001 Parameter MAX_LEN, default 32, meaning: message buffer depth in symbols (range 1..255).
REQ-002 clk_i  input  1  sole clock, all logic on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 in_val_i  input  1  upstream symbol valid.
REQ-005 in_symb_i  input  7 (signed)  upstream plaintext symbol.
REQ-006 in_last_i  input  1  marks final symbol of a message; qualified by in_val_i.
REQ-007 in_rdy_o  output  1  feeder can accept a symbol this cycle.
REQ-008 rotors_rst_o  output  1  one-cycle pulse to the cipher core's rotor reset input.
REQ-009 symb_numb_o  output  8  length of the message being played out.
REQ-010 symb_val_o  output  1  symbol_o valid toward the cipher core.
REQ-011 symbol_o  output  7 (signed)  buffered symbol toward the cipher core.
REQ-012 ovf_o  output  1  current or last message exceeded MAX_LEN; extra symbols dropped.
REQ-013 busy_o  output  1  high in every state other than IDLE.

Function
REQ-014 The feeder SHALL implement the states IDLE, LOAD, START, SEND.
REQ-015 A transfer SHALL occur only in a cycle where in_val_i=1 and in_rdy_o=1.
REQ-016 in_rdy_o SHALL be 1 in IDLE and LOAD and 0 in START and SEND.
REQ-017 IDLE: on a transfer, the feeder SHALL write the symbol to buffer slot 0, set count=1, clear ovf_o, and go to LOAD; if in_last_i=1, it SHALL go directly to START.
REQ-018 LOAD: each transfer with count<MAX_LEN SHALL write to slot count and increment count; with count=MAX_LEN, the symbol SHALL be dropped and ovf_o set to 1.
REQ-019 LOAD: a transfer with in_last_i=1 SHALL go to START after applying REQ-018 to that symbol.
REQ-020 START lasts exactly one cycle: rotors_rst_o=1, and symb_numb_o SHALL be loaded with count in that same cycle.
REQ-021 SEND SHALL start in the cycle after START.
REQ-022 SEND: symb_val_o SHALL be 1 for exactly count consecutive cycles, with symbol_o = slot 0, 1, ..., count-1 in order and no gaps.
REQ-023 After the last SEND cycle, the feeder SHALL return to IDLE, and symb_val_o SHALL be 0 in the following cycle.
REQ-024 symb_numb_o SHALL hold its value from START until the next START.
REQ-025 ovf_o SHALL hold its value until the first transfer of the next message.
REQ-026 symbol_o SHALL be 0 whenever symb_val_o=0.
REQ-027 Symbols SHALL pass through unmodified (no range check); the read pointer SHALL be log2(MAX_LEN) bits plus margin and SHALL never address beyond count-1.
REQ-028 Latency: the accept of the last symbol in cycle N SHALL give rotors_rst_o in N+1 and the first symb_val_o in N+2.
REQ-029 All outputs SHALL be registered.
REQ-030 in_val_i while in START or SEND SHALL be ignored; upstream SHALL hold the symbol until in_rdy_o=1.
REQ-031 A single-symbol message (in_last_i on first transfer) SHALL give count=1, one START cycle, and one SEND cycle.

Reset
REQ-032 While rst_i=1 at a clock edge, the feeder SHALL go to IDLE, clear count and pointers, and drive in_rdy_o=0, rotors_rst_o=0, symb_numb_o=0, symb_val_o=0, symbol_o=0, ovf_o=0, busy_o=0.
REQ-033 In the cycle after rst_i deasserts, the feeder SHALL drive in_rdy_o=1.
REQ-034 A reset in LOAD, START, or SEND SHALL discard the partial message with no further symb_val_o or rotors_rst_o.
REQ-035 Buffer contents need not be reset.

Verification
REQ-036 Basic message: feed 3, 5, -2 with in_last_i on -2 -> rotors_rst_o for 1 cycle with symb_numb_o=3, then symb_val_o for 3 cycles carrying 3, 5, -2, then idle.
REQ-037 Single symbol: feed 7 with in_last_i=1 in cycle N -> rotors_rst_o at N+1, symbol_o=7 valid at N+2 only, symb_numb_o=1.
REQ-038 Overflow (MAX_LEN=32): feed 40 symbols 0..39, last on 39 -> symb_numb_o=32, output 0..31, ovf_o=1; next message clears ovf_o on its first transfer.
REQ-039 Backpressure: hold in_val_i=1 through START/SEND -> in_rdy_o=0, no writes, and the held symbol is accepted as slot 0 in the first IDLE cycle.
REQ-040 Mid-send reset: assert rst_i during the 2nd SEND cycle of a 5-symbol message -> all outputs 0 the next cycle, and a new message plays out correctly afterwards.
REQ-041 Gapped input: in_val_i toggling every other cycle over 4 symbols -> contiguous 4-cycle SEND with the correct order.

Source files
------------

// File: rtl/enigma_msg_feeder.sv
// rtl/enigma_msg_feeder.sv - buffers one message of signed symbols and replays it to the cipher core
module enigma_msg_feeder #(
  parameter int MAX_LEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_val_i,
  input  logic signed [6:0] in_symb_i,
  input  logic              in_last_i,
  output logic              in_rdy_o,
  output logic              rotors_rst_o,
  output logic [7:0]        symb_numb_o,
  output logic              symb_val_o,
  output logic signed [6:0] symbol_o,
  output logic              ovf_o,
  output logic              busy_o
);

  // AW holds 0..MAX_LEN; IW addresses the buffer slots.
  localparam int AW    = $clog2(MAX_LEN + 1);
  localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << IW;
  localparam logic [AW-1:0] MAX_CNT = AW'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_SEND} state_t;

  state_t            r_state, w_state_next;
  logic [AW-1:0]     r_count, w_count_next;
  logic [AW-1:0]     r_rd_ptr, w_rd_ptr_next;
  logic signed [6:0] r_mem [0:DEPTH-1];

  logic              r_in_rdy, r_rotors_rst, r_symb_val, r_ovf, r_busy;
  logic [7:0]        r_symb_numb;
  logic signed [6:0] r_symbol;

  logic              w_xfer, w_full, w_wr_en, w_ovf_next, w_send_val;
  logic [IW-1:0]     w_wr_idx, w_rd_idx;

  assign w_xfer = in_val_i & r_in_rdy;
  assign w_full = (r_count == MAX_CNT);

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_rd_ptr_next = r_rd_ptr;
    w_wr_en       = 1'b0;
    w_wr_idx      = r_count[IW-1:0];
    w_ovf_next    = r_ovf;
    w_send_val    = 1'b0;
    w_rd_idx      = r_rd_ptr[IW-1:0];
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_wr_en      = 1'b1;
          w_wr_idx     = '0;
          w_count_next = AW'(1);
          w_ovf_next   = 1'b0;
          w_state_next = in_last_i ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          if (w_full) begin
            w_ovf_next = 1'b1;
          end else begin
            w_wr_en      = 1'b1;
            w_count_next = r_count + AW'(1);
          end
          if (in_last_i) begin
            w_state_next = S_START;
          end
        end
      end
      S_START: begin
        // Slot 0 is fetched here so SEND begins with valid data and no bubble.
        w_send_val    = 1'b1;
        w_rd_idx      = '0;
        w_rd_ptr_next = AW'(1);
        w_state_next  = S_SEND;
      end
      S_SEND: begin
        if (r_rd_ptr < r_count) begin
          w_send_val    = 1'b1;
          w_rd_ptr_next = r_rd_ptr + AW'(1);
        end else begin
          w_rd_ptr_next = '0;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_in_rdy     <= 1'b0;
      r_rotors_rst <= 1'b0;
      r_symb_numb  <= '0;
      r_symb_val   <= 1'b0;
      r_symbol     <= '0;
      r_ovf        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_rd_ptr     <= w_rd_ptr_next;
      r_in_rdy     <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD);
      r_rotors_rst <= (w_state_next == S_START);
      r_busy       <= (w_state_next != S_IDLE);
      r_ovf        <= w_ovf_next;
      r_symb_val   <= w_send_val;
      r_symbol     <= w_send_val ? r_mem[w_rd_idx] : '0;
      if (w_state_next == S_START) begin
        r_symb_numb <= 8'(w_count_next);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= in_symb_i;
    end
  end

  assign in_rdy_o     = r_in_rdy;
  assign rotors_rst_o = r_rotors_rst;
  assign symb_numb_o  = r_symb_numb;
  assign symb_val_o   = r_symb_val;
  assign symbol_o     = r_symbol;
  assign ovf_o        = r_ovf;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_enigma_msg_feeder.sv
// tb/tb_enigma_msg_feeder.sv - self-checking bench for enigma_msg_feeder
module tb_enigma_msg_feeder;
  localparam int MAXL = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_val = 1'b0;
  logic signed [6:0] in_symb = '0;
  logic              in_last = 1'b0;
  logic              in_rdy_o, rotors_rst_o, symb_val_o, ovf_o, busy_o;
  logic [7:0]        symb_numb_o;
  logic signed [6:0] symbol_o;

  enigma_msg_feeder #(.MAX_LEN(MAXL)) dut (
    .clk_i(clk), .rst_i(rst), .in_val_i(in_val), .in_symb_i(in_symb), .in_last_i(in_last),
    .in_rdy_o(in_rdy_o), .rotors_rst_o(rotors_rst_o), .symb_numb_o(symb_numb_o),
    .symb_val_o(symb_val_o), .symbol_o(symbol_o), .ovf_o(ovf_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int syms [0:127];
  int q_rot[$], q_numb[$], q_vcyc[$], q_vsym[$];
  int zero_viol = 0;
  int first_acc, last_acc, ovf_before, ovf_after_first;
  int prev_ovf = 0;

  typedef struct {
    int len;
    int gap;
    int pat;
    int exp_numb;
    int exp_ovf;
  } vec_t;
  vec_t tbl [7];

  always @(negedge clk) begin
    if (rotors_rst_o) begin
      q_rot.push_back(cyc);
      q_numb.push_back(int'(symb_numb_o));
    end
    if (symb_val_o) begin
      q_vcyc.push_back(cyc);
      q_vsym.push_back(int'(symbol_o));
    end else if (symbol_o != 7'sd0) begin
      zero_viol++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    q_rot.delete();
    q_numb.delete();
    q_vcyc.delete();
    q_vsym.delete();
  endtask

  task automatic fill_syms(input int base, input int len, input int pat);
    for (int i = 0; i < len; i++) begin
      case (pat)
        1: syms[base+i] = i;
        2: syms[base+i] = (i == 0) ? 3 : (i == 1) ? 5 : -2;
        3: syms[base+i] = 7;
        default: syms[base+i] = int'($urandom_range(0, 127)) - 64;
      endcase
    end
  endtask

  // gap: 0 back-to-back, 1 one idle cycle between symbols, 2 random 0..2 idle cycles
  task automatic send_msg(input int base, input int len, input int gap);
    int w;
    int g;
    for (int i = 0; i < len; i++) begin
      g = (i == 0) ? 0 : (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        in_val = 1'b0;
        tick();
      end
      in_val  = 1'b1;
      in_symb = 7'(syms[base+i]);
      in_last = (i == len - 1);
      w = 0;
      while (!in_rdy_o && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) begin
        chk("rdy_timeout", 0, 1);
        in_val = 1'b0;
        in_last = 1'b0;
        return;
      end
      if (i == 0) begin
        first_acc  = cyc;
        ovf_before = int'(ovf_o);
      end
      if (i == len - 1) last_acc = cyc;
      tick();
      if (i == 0) ovf_after_first = int'(ovf_o);
    end
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic check_msg(input string tag, input int base, input int len, input int exp_numb,
                           input int exp_ovf);
    int k;
    int n;
    k = (len < MAXL) ? len : MAXL;
    repeat (k + 4) tick();
    chk({tag, ".rot_count"}, q_rot.size(), 1);
    if (q_rot.size() >= 1) begin
      chk({tag, ".rot_cycle"}, q_rot[0], last_acc + 1);
      chk({tag, ".numb_at_start"}, q_numb[0], exp_numb);
    end
    chk({tag, ".val_count"}, q_vcyc.size(), k);
    n = (q_vcyc.size() < k) ? q_vcyc.size() : k;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.val_cycle[%0d]", tag, i), q_vcyc[i], last_acc + 2 + i);
      chk($sformatf("%s.symbol[%0d]", tag, i), q_vsym[i], syms[base+i]);
    end
    chk({tag, ".ovf"}, int'(ovf_o), exp_ovf);
    chk({tag, ".numb_hold"}, int'(symb_numb_o), exp_numb);
    chk({tag, ".busy_idle"}, int'(busy_o), 0);
    chk({tag, ".rdy_idle"}, int'(in_rdy_o), 1);
    chk({tag, ".zero_when_invalid"}, zero_viol, 0);
    chk({tag, ".ovf_held"}, ovf_before, prev_ovf);
    chk({tag, ".ovf_cleared_first"}, ovf_after_first, 0);
    prev_ovf = exp_ovf;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rdy"}, int'(in_rdy_o), 0);
    chk({tag, ".rotors"}, int'(rotors_rst_o), 0);
    chk({tag, ".numb"}, int'(symb_numb_o), 0);
    chk({tag, ".val"}, int'(symb_val_o), 0);
    chk({tag, ".symbol"}, int'(symbol_o), 0);
    chk({tag, ".ovf"}, int'(ovf_o), 0);
    chk({tag, ".busy"}, int'(busy_o), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int k;
    tbl[0] = '{3, 0, 2, 3, 0};
    tbl[1] = '{1, 0, 3, 1, 0};
    tbl[2] = '{40, 0, 1, 32, 1};
    tbl[3] = '{4, 1, 0, 4, 0};
    tbl[4] = '{32, 0, 0, 32, 0};
    tbl[5] = '{33, 2, 0, 32, 1};
    tbl[6] = '{7, 0, 0, 7, 0};

    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("post_reset.rdy", int'(in_rdy_o), 1);
    chk("post_reset.busy", int'(busy_o), 0);

    for (int t = 0; t < 7; t++) begin
      fill_syms(0, tbl[t].len, tbl[t].pat);
      clear_mon();
      send_msg(0, tbl[t].len, tbl[t].gap);
      check_msg($sformatf("tbl%0d", t), 0, tbl[t].len, tbl[t].exp_numb, tbl[t].exp_ovf);
    end

    // Backpressure: second message is presented while the first is still playing out.
    fill_syms(0, 5, 0);
    clear_mon();
    send_msg(0, 3, 0);
    k = last_acc;
    send_msg(3, 2, 0);
    chk("bp.first_accept_cycle", first_acc, k + 2 + 3);
    repeat (8) tick();
    chk("bp.rot_count", q_rot.size(), 2);
    chk("bp.val_count", q_vsym.size(), 5);
    if (q_numb.size() == 2) begin
      chk("bp.numb0", q_numb[0], 3);
      chk("bp.numb1", q_numb[1], 2);
    end
    for (int i = 0; i < 5 && i < q_vsym.size(); i++)
      chk($sformatf("bp.symbol[%0d]", i), q_vsym[i], syms[i]);
    chk("bp.numb_hold", int'(symb_numb_o), 2);

    // Reset during the second SEND cycle of a five-symbol message.
    fill_syms(0, 5, 0);
    clear_mon();
    send_msg(0, 5, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    tick();
    chk("midrst.rdy_after", int'(in_rdy_o), 1);
    repeat (6) tick();
    chk("midrst.val_count", q_vcyc.size(), 2);
    chk("midrst.rot_count", q_rot.size(), 1);
    chk("midrst.still_idle", int'(busy_o), 0);
    prev_ovf = 0;

    for (int r = 0; r < 12; r++) begin
      len = int'($urandom_range(1, 45));
      fill_syms(0, len, 0);
      clear_mon();
      send_msg(0, len, 2);
      check_msg($sformatf("rnd%0d", r), 0, len, (len < MAXL) ? len : MAXL, (len > MAXL) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
